// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop synchronisers, per-bit debounce, priority note
// encoder with change strobe, and a saturating three-level octave register.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_raw,
  input  logic [1:0] octave_raw,
  output logic [3:0] note,
  output logic       note_change,
  output logic       octave_up,
  output logic       octave_down,
  output logic [1:0] octave_state
);

  localparam int NB = 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    OCT_LOW  = 2'd0,
    OCT_MID  = 2'd1,
    OCT_HIGH = 2'd2
  } oct_t;

  logic [NB-1:0] s1, s2, stable;
  logic [1:0]    oct_stable_q;
  logic [3:0]    note_next;
  logic          up_rise, down_rise;
  logic          octave_up_next, octave_down_next;
  oct_t          state, state_next;

  // Bits 6:0 are note keys, bits 8:7 are octave up/down.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {octave_raw, key_raw};
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_debounce
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt       <= '0;
        stable[g] <= 1'b0;
      end else if (s2[g] == stable[g]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable[g] <= s2[g];
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Lowest set key wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    note_next = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (stable[i]) note_next = 4'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note        <= 4'd0;
      note_change <= 1'b0;
    end else begin
      note        <= note_next;
      note_change <= (note_next != note);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) oct_stable_q <= 2'b00;
    else     oct_stable_q <= stable[8:7];
  end

  assign up_rise   = stable[7] & ~oct_stable_q[0];
  assign down_rise = stable[8] & ~oct_stable_q[1];

  always_ff @(posedge clk) begin
    if (rst) state <= OCT_MID;
    else     state <= state_next;
  end

  // Simultaneous up and down edges cancel out.
  always_comb begin
    state_next = state;
    if (up_rise && !down_rise) begin
      case (state)
        OCT_LOW: state_next = OCT_MID;
        OCT_MID: state_next = OCT_HIGH;
        default: state_next = state;
      endcase
    end else if (down_rise && !up_rise) begin
      case (state)
        OCT_HIGH: state_next = OCT_MID;
        OCT_MID:  state_next = OCT_LOW;
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    octave_up_next   = (state == OCT_HIGH);
    octave_down_next = (state == OCT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      octave_up   <= 1'b0;
      octave_down <= 1'b0;
    end else begin
      octave_up   <= octave_up_next;
      octave_down <= octave_down_next;
    end
  end

  assign octave_state = state;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with a 4-cycle debounce: exact-latency and corner
// sequences by hand, then a vector table checked through an expected queue.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int W  = 10;
  localparam int NV = 21;
  localparam int HOLD = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] key_raw;
  logic [1:0] octave_raw;
  logic [3:0] note;
  logic       note_change;
  logic       octave_up;
  logic       octave_down;
  logic [1:0] octave_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [6:0] key;
    logic [1:0] oct;
    logic [3:0] note;
    logic       up;
    logic       dn;
    logic [1:0] st;
    logic [1:0] chg;
  } vec_t;

  vec_t vecs[NV];

  key_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .octave_raw  (octave_raw),
    .note        (note),
    .note_change (note_change),
    .octave_up   (octave_up),
    .octave_down (octave_down),
    .octave_state(octave_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] key, input logic [1:0] oct, input logic [3:0] n,
                              input logic up, input logic dn, input logic [1:0] st,
                              input logic [1:0] chg);
    vec_t v;
    v.key = key; v.oct = oct; v.note = n; v.up = up; v.dn = dn; v.st = st; v.chg = chg;
    return v;
  endfunction

  initial begin
    int pulses;
    logic [W-1:0] exp_v, act_v;

    // state: 0 = LOW, 1 = MID, 2 = HIGH
    vecs[0]  = mk(7'b0000100, 2'b00, 4'd3, 0, 0, 2'd1, 2'd1);
    vecs[1]  = mk(7'b0000000, 2'b00, 4'd0, 0, 0, 2'd1, 2'd1);
    vecs[2]  = mk(7'b0100010, 2'b00, 4'd2, 0, 0, 2'd1, 2'd1);
    vecs[3]  = mk(7'b0100000, 2'b00, 4'd6, 0, 0, 2'd1, 2'd1);
    vecs[4]  = mk(7'b0100000, 2'b01, 4'd6, 1, 0, 2'd2, 2'd0);
    vecs[5]  = mk(7'b0000000, 2'b00, 4'd0, 1, 0, 2'd2, 2'd1);
    vecs[6]  = mk(7'b0000000, 2'b01, 4'd0, 1, 0, 2'd2, 2'd0);
    vecs[7]  = mk(7'b0000000, 2'b00, 4'd0, 1, 0, 2'd2, 2'd0);
    vecs[8]  = mk(7'b0000000, 2'b01, 4'd0, 1, 0, 2'd2, 2'd0);
    vecs[9]  = mk(7'b0000000, 2'b00, 4'd0, 1, 0, 2'd2, 2'd0);
    vecs[10] = mk(7'b0000000, 2'b10, 4'd0, 0, 0, 2'd1, 2'd0);
    vecs[11] = mk(7'b0000000, 2'b00, 4'd0, 0, 0, 2'd1, 2'd0);
    vecs[12] = mk(7'b0000000, 2'b10, 4'd0, 0, 1, 2'd0, 2'd0);
    vecs[13] = mk(7'b0000000, 2'b00, 4'd0, 0, 1, 2'd0, 2'd0);
    vecs[14] = mk(7'b0000000, 2'b10, 4'd0, 0, 1, 2'd0, 2'd0);
    vecs[15] = mk(7'b0000000, 2'b00, 4'd0, 0, 1, 2'd0, 2'd0);
    vecs[16] = mk(7'b0000000, 2'b11, 4'd0, 0, 1, 2'd0, 2'd0);
    vecs[17] = mk(7'b0000000, 2'b00, 4'd0, 0, 1, 2'd0, 2'd0);
    vecs[18] = mk(7'b1000000, 2'b00, 4'd7, 0, 1, 2'd0, 2'd1);
    vecs[19] = mk(7'b1111111, 2'b00, 4'd1, 0, 1, 2'd0, 2'd1);
    vecs[20] = mk(7'b0000000, 2'b00, 4'd0, 0, 1, 2'd0, 2'd1);

    // Reset held for three cycles with all inputs idle.
    rst = 1'b1; key_raw = '0; octave_raw = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset_note_%0d", c), 32'(note), 32'd0);
      check($sformatf("reset_chg_%0d", c), 32'(note_change), 32'd0);
      check($sformatf("reset_oct_%0d", c), {30'd0, octave_up, octave_down}, 32'd0);
      check($sformatf("reset_state_%0d", c), 32'(octave_state), 32'd1);
    end
    rst = 1'b0;
    tick(); tick();

    // Clean press: note appears exactly DB+3 edges after the raw change.
    key_raw = 7'b0000100;
    for (int c = 1; c <= DB + 4; c++) begin
      tick();
      if (c == DB + 2) check("lat_note_before", 32'(note), 32'd0);
      if (c == DB + 3) begin
        check("lat_note_at", 32'(note), 32'd3);
        check("lat_chg_at", 32'(note_change), 32'd1);
      end
      if (c == DB + 4) check("lat_chg_after", 32'(note_change), 32'd0);
    end
    key_raw = '0;
    for (int c = 1; c <= DB + 3; c++) begin
      tick();
      if (c == DB + 2) check("rel_note_before", 32'(note), 32'd3);
      if (c == DB + 3) check("rel_note_at", 32'(note), 32'd0);
    end
    repeat (4) tick();

    // Bounce 1,0 of two cycles each, then held: only the held level counts.
    pulses = 0;
    key_raw = 7'b0000001;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) key_raw = 7'b0000000;
      if (c == 5) key_raw = 7'b0000001;
      tick();
      if (note_change) pulses++;
      if (c == 10) check("bounce_note_before", 32'(note), 32'd0);
      if (c == 11) check("bounce_note_at", 32'(note), 32'd1);
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    key_raw = '0;
    repeat (12) tick();

    // Vector table through the expected queue.
    for (int i = 0; i < NV; i++) begin
      key_raw    = vecs[i].key;
      octave_raw = vecs[i].oct;
      exp_q.push_back({vecs[i].note, vecs[i].up, vecs[i].dn, vecs[i].st, vecs[i].chg});
      pulses = 0;
      for (int c = 0; c < HOLD; c++) begin
        tick();
        if (note_change) pulses++;
      end
      act_v = {note, octave_up, octave_down, octave_state, 2'(pulses)};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec_%0d: expected queue empty", i);
      end else begin
        exp_v = exp_q.pop_front();
        check($sformatf("vec_%0d {note,up,dn,st,chg}", i), 32'(act_v), 32'(exp_v));
      end
    end

    // Reset in the middle of a debounce: the count restarts and octave returns to MID.
    key_raw = 7'b0001000;
    pulses = 0;
    for (int c = 1; c <= DB + 10; c++) begin
      rst = (c == 5);
      tick();
      if (note_change) pulses++;
      if (c == 5) begin
        check("midrst_note", 32'(note), 32'd0);
        check("midrst_oct", {30'd0, octave_up, octave_down}, 32'd0);
        check("midrst_state", 32'(octave_state), 32'd1);
      end
      if (c == 11) check("midrst_note_before", 32'(note), 32'd0);
      if (c == 12) check("midrst_note_at", 32'(note), 32'd4);
    end
    rst = 1'b0;
    check("midrst_pulses", 32'(pulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
